// File: rtl/float_to_fixed_iter.sv
// float_to_fixed_iter
//   Iterative IEEE-754 single-precision to signed 32-bit fixed-point converter.
//   The work register moves one bit per clock, so a conversion takes
//   |sh|+1 cycles, where sh = exp - 150 + fixpointpos.
//
// Parameters
//   MAX_SHIFT : largest right shift that is actually iterated; anything
//               further right resolves straight to zero.
//
// Ports
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   in_valid        : floatnumber/fixpointpos valid
//   in_ready        : converter idle and able to accept
//   floatnumber     : IEEE-754 single input word
//   fixpointpos     : number of fractional bits in result (0..31)
//   out_valid       : result/out_ovf valid, held until out_ready
//   out_ready       : consumer takes the result
//   result          : two's-complement fixed-point value
//   out_ovf         : result saturated (overflow, Inf or NaN)
//
// Build option
//   FLOAT_TO_FIXED_ROUND_NEAREST_EN : keep the last bit shifted out on right
//   shifts and round half away from zero; without it the result truncates
//   toward zero.
module float_to_fixed_iter #(
  parameter int MAX_SHIFT = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] floatnumber,
  input  logic [4:0]  fixpointpos,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        out_ovf
);

  localparam int CNT_W = $clog2(MAX_SHIFT + 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_SIGN  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic signed [9:0] LIM_NEG = 10'(-MAX_SHIFT);
  localparam logic signed [9:0] LIM_POS = 10'sd7;

  // Saturate or negate the final magnitude.
  function automatic logic signed [31:0] f_sign(input logic [31:0] mag,
                                                input logic        neg,
                                                input logic        sat);
    logic signed [31:0] v;
    v = $signed(mag);
    if (sat)
      v = neg ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    else if (neg)
      v = -$signed(mag);  // zero magnitude stays zero, so no -0
    return v;
  endfunction

`ifdef FLOAT_TO_FIXED_ROUND_NEAREST_EN
  // Magnitude is at most 24 bits after a right shift, so +1 cannot overflow.
  function automatic logic [31:0] f_round(input logic [31:0] mag,
                                          input logic        guard);
    return mag + {31'b0, guard};
  endfunction
`endif

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic signed [31:0] r_result;
  logic               r_ovf;
  logic [31:0]        r_work;
  logic               r_left;
  logic               r_sign;
  logic               r_sat;
`ifdef FLOAT_TO_FIXED_ROUND_NEAREST_EN
  logic               r_guard;
`endif

  logic [7:0]         w_exp;
  logic signed [9:0]  w_sh;
  logic [CNT_W-1:0]   w_lo;
  logic [CNT_W-1:0]   w_cnt;
  logic               w_accept;
  logic               w_zero_in;
  logic               w_sat_in;
  logic               w_noshift;
  logic [31:0]        w_mag;
  logic signed [31:0] w_final;

  assign w_exp    = floatnumber[30:23];
  assign w_sh     = $signed({2'b00, w_exp}) - 10'sd150 + $signed({5'b00000, fixpointpos});
  // Low bits of |sh| are enough: the count is only used when -MAX_SHIFT <= sh <= 7.
  assign w_lo     = w_sh[CNT_W-1:0];
  assign w_cnt    = w_sh[9] ? (~w_lo + 1'b1) : w_lo;
  assign w_accept = in_valid && (r_state == S_IDLE);

  assign w_sat_in  = (w_exp == 8'hFF) || ((w_exp != 8'h00) && (w_sh > LIM_POS));
  assign w_zero_in = (w_exp == 8'h00) || (!w_sat_in && (w_sh < LIM_NEG));
  assign w_noshift = w_sat_in || w_zero_in || (w_sh == 10'sd0);

`ifdef FLOAT_TO_FIXED_ROUND_NEAREST_EN
  assign w_mag = f_round(r_work, r_guard);
`else
  assign w_mag = r_work;
`endif
  assign w_final = f_sign(w_mag, r_sign, r_sat);

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign out_ovf   = r_ovf;

  // Control: state, iteration counter and the registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt   <= w_cnt;
            r_state <= w_noshift ? S_SIGN : S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1))
            r_state <= S_SIGN;
        end
        S_SIGN: begin
          r_result <= w_final;
          r_ovf    <= r_sat;
          r_state  <= S_DONE;
        end
        default: begin
          if (out_ready)
            r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Datapath: operand capture and the one-bit-per-cycle shifter.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_sign <= floatnumber[31];
      r_sat  <= w_sat_in;
      r_left <= ~w_sh[9];
      r_work <= w_zero_in ? 32'd0 : {8'd0, 1'b1, floatnumber[22:0]};
`ifdef FLOAT_TO_FIXED_ROUND_NEAREST_EN
      r_guard <= 1'b0;
`endif
    end else if (r_state == S_SHIFT) begin
      if (r_left) begin
        r_work <= r_work << 1;
      end else begin
        r_work <= r_work >> 1;
`ifdef FLOAT_TO_FIXED_ROUND_NEAREST_EN
        r_guard <= r_work[0];
`endif
      end
    end
  end

endmodule

// File: tb/tb_float_to_fixed_iter.sv
module tb_float_to_fixed_iter;

`ifdef FLOAT_TO_FIXED_ROUND_NEAREST_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] floatnumber;
  logic [4:0]  fixpointpos;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        out_ovf;

  always #5 clk = ~clk;

  float_to_fixed_iter #(.MAX_SHIFT(24)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .floatnumber (floatnumber),
    .fixpointpos (fixpointpos),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .out_ovf     (out_ovf)
  );

  typedef struct {
    logic [31:0] f;
    logic [4:0]  fp;
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One conversion: wait for in_ready, present the operands for one edge,
  // scramble the inputs afterwards, then count edges until out_valid.
  task automatic convert(input logic [31:0] f, input logic [4:0] fp,
                         output logic [31:0] res, output logic ovf, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    in_valid    = 1'b1;
    floatnumber = f;
    fixpointpos = fp;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    floatnumber = ~f;
    fixpointpos = fp ^ 5'h1F;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 100);
    res = result;
    ovf = out_ovf;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  vec_t        vecs[18];
  logic [31:0] r;
  logic        o;
  int          l;
  logic [31:0] held;

  initial begin
    //             float         fp     result                         ovf   latency
    vecs[0]  = '{32'h3F800000, 5'd0,  32'h00000001,                 1'b0, 24}; // 1.0
    vecs[1]  = '{32'hC0200000, 5'd4,  32'hFFFFFFD8,                 1'b0, 19}; // -2.5 -> -40
    vecs[2]  = '{32'h4F800000, 5'd0,  32'h7FFFFFFF,                 1'b1, 1};  // 2^32
    vecs[3]  = '{32'hCF800000, 5'd0,  32'h80000000,                 1'b1, 1};  // -2^32
    vecs[4]  = '{32'h3F800000, 5'd31, 32'h7FFFFFFF,                 1'b1, 1};  // sh=8
    vecs[5]  = '{32'h00000000, 5'd5,  32'h00000000,                 1'b0, 1};  // +0
    vecs[6]  = '{32'h80000000, 5'd0,  32'h00000000,                 1'b0, 1};  // -0
    vecs[7]  = '{32'h7FC00000, 5'd0,  32'h7FFFFFFF,                 1'b1, 1};  // NaN
    vecs[8]  = '{32'h3F400000, 5'd1,  RND ? 32'd2 : 32'd1,          1'b0, 24}; // 0.75 q1
    vecs[9]  = '{32'h3F800000, 5'd23, 32'h00800000,                 1'b0, 1};  // sh=0
    vecs[10] = '{32'h3F800000, 5'd30, 32'h40000000,                 1'b0, 8};  // sh=7
    vecs[11] = '{32'hBF800000, 5'd30, 32'hC0000000,                 1'b0, 8};  // -1.0 sh=7
    vecs[12] = '{32'h3F000000, 5'd0,  RND ? 32'd1 : 32'd0,          1'b0, 25}; // 0.5, sh=-24
    vecs[13] = '{32'h3E800000, 5'd0,  32'h00000000,                 1'b0, 1};  // 0.25, sh=-25
    vecs[14] = '{32'h00400000, 5'd31, 32'h00000000,                 1'b0, 1};  // denormal
    vecs[15] = '{32'hBF400000, 5'd1,  RND ? 32'hFFFFFFFE : 32'hFFFFFFFF, 1'b0, 24}; // -0.75 q1
    vecs[16] = '{32'h40400000, 5'd16, 32'h00030000,                 1'b0, 7};  // 3.0 q16
    vecs[17] = '{32'hFF800000, 5'd3,  32'h80000000,                 1'b1, 1};  // -Inf

    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    floatnumber = '0;
    fixpointpos = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready",  {31'd0, in_ready},  32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset result",    result,             32'd0);
    chk("reset out_ovf",   {31'd0, out_ovf},   32'd0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      convert(vecs[i].f, vecs[i].fp, r, o, l);
      chk($sformatf("v%0d result", i), r, vecs[i].res);
      chk($sformatf("v%0d ovf", i), {31'd0, o}, {31'd0, vecs[i].ovf});
      chk($sformatf("v%0d latency", i), l, vecs[i].lat);
      release_out();
      chk($sformatf("v%0d valid_drop", i), {31'd0, out_valid}, 32'd0);
    end

    // Back-pressure in DONE: result must hold and new inputs be ignored.
    convert(32'h3F800000, 5'd23, r, o, l);
    chk("hold first", r, 32'h00800000);
    held = r;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid    = 1'b1;
      floatnumber = 32'h40400000;
      fixpointpos = 5'd16;
      @(negedge clk);
      chk($sformatf("hold%0d result", k), result, held);
      chk($sformatf("hold%0d in_ready", k), {31'd0, in_ready}, 32'd0);
      chk($sformatf("hold%0d out_valid", k), {31'd0, out_valid}, 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_out();
    chk("hold released out_valid", {31'd0, out_valid}, 32'd0);
    chk("hold released in_ready", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of a long right shift.
    @(negedge clk);
    in_valid    = 1'b1;
    floatnumber = 32'h3F800000;
    fixpointpos = 5'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst result", result, 32'd0);
    chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst out_ovf", {31'd0, out_ovf}, 32'd0);
    rst = 1'b0;
    convert(32'h3F800000, 5'd0, r, o, l);
    chk("post rst result", r, 32'h00000001);
    chk("post rst ovf", {31'd0, o}, 32'd0);
    chk("post rst latency", l, 24);
    release_out();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
